// File: rtl/mouse_ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package mouse_ps2_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_DATA   = 3'd1,
        READ_PARITY = 3'd2,
        READ_STOP   = 3'd3,
        SEND_BYTE   = 3'd4
    } rx_state_e;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned ERR_W          = 2;
    localparam int unsigned BIT_CNT_W      = 3;
    localparam int unsigned TIMEOUT_CYCLES = 10000;
    localparam int unsigned TIMEOUT_W      = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned FILTER_W       = $clog2(FILTER_LEN);
    localparam int unsigned ERR_PARITY_BIT = 0;
    localparam int unsigned ERR_STOP_BIT   = 1;

    typedef struct packed {
        logic [ERR_W-1:0]  err;
        logic [BYTE_W-1:0] data;
    } rx_result_t;

endpackage

// File: rtl/mouse_receiver_if.sv
// Mouse-line inputs and received-byte outputs of the PS/2 receiver.
interface mouse_receiver_if;
    import mouse_ps2_pkg::*;

    logic              CLK_MOUSE_IN;
    logic              DATA_MOUSE_IN;
    logic              READ_ENABLE;
    logic [BYTE_W-1:0] BYTE_READ;
    logic [ERR_W-1:0]  BYTE_ERROR_CODE;
    logic              BYTE_READY;

    modport master (
        output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
        input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );

    modport slave (
        input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
        output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 line synchronisers and mouse-clock falling-edge detector.
// Optional clock glitch filter enabled by MOUSE_RECEIVER_GLITCH_FILTER_EN.
module ps2_line_sync
    import mouse_ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clk_raw,
    input  logic data_raw,
    output logic data_sync,
    output logic fall_edge_c
);

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       prev_q, prev_d;
    logic       clk_cur;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], clk_raw};
        data_sync_d = {data_sync_q[0], data_raw};
    end

`ifdef MOUSE_RECEIVER_GLITCH_FILTER_EN
    logic                filt_q, filt_d;
    logic [FILTER_W-1:0] fcnt_q, fcnt_d;

    // Adopt a new clock level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FILTER_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign clk_cur = filt_q;
`else
    assign clk_cur = clk_sync_q[1];
`endif

    always_comb begin
        prev_d = clk_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            prev_q      <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            prev_q      <= prev_d;
        end
    end

    assign data_sync   = data_sync_q[1];
    assign fall_edge_c = prev_q & ~clk_cur;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 mouse byte receiver: frame FSM, data shifter, bit and timeout counters.
module mouse_receiver
    import mouse_ps2_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    mouse_receiver_if.slave  bus
);

    logic data_sync;
    logic fall_edge_c;

    ps2_line_sync u_sync (
        .clk         (CLK),
        .rst_n       (RESET),
        .clk_raw     (bus.CLK_MOUSE_IN),
        .data_raw    (bus.DATA_MOUSE_IN),
        .data_sync   (data_sync),
        .fall_edge_c (fall_edge_c)
    );

    rx_state_e            state_q, state_d;
    logic [BYTE_W-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 parity_err_q, parity_err_d;
    rx_result_t           result_q, result_d;
    logic                 byte_ready_q, byte_ready_d;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        tmo_d        = tmo_q;
        parity_err_d = parity_err_q;
        result_d     = result_q;
        byte_ready_d = 1'b0;

        if (state_q == IDLE || fall_edge_c) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall_edge_c && !data_sync && bus.READ_ENABLE) begin
                    state_d   = READ_DATA;
                    bit_cnt_d = '0;
                end
            end
            READ_DATA: begin
                if (fall_edge_c) begin
                    shift_d   = {data_sync, shift_q[BYTE_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
                        state_d = READ_PARITY;
                    end
                end
            end
            READ_PARITY: begin
                if (fall_edge_c) begin
                    parity_err_d = ~(^shift_q ^ data_sync);
                    state_d      = READ_STOP;
                end
            end
            READ_STOP: begin
                // Outputs and the ready pulse land together while in SEND_BYTE.
                if (fall_edge_c) begin
                    result_d.data                    = shift_q;
                    result_d.err[1'(ERR_PARITY_BIT)] = parity_err_q;
                    result_d.err[1'(ERR_STOP_BIT)]   = ~data_sync;
                    byte_ready_d                     = 1'b1;
                    state_d                          = SEND_BYTE;
                end
            end
            SEND_BYTE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A falling edge in the same cycle always beats the timeout.
        if (state_q != IDLE && state_q != SEND_BYTE && !fall_edge_c &&
            tmo_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            parity_err_q <= 1'b0;
            result_q     <= '0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            parity_err_q <= parity_err_d;
            result_q     <= result_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    assign bus.BYTE_READ       = result_q.data;
    assign bus.BYTE_ERROR_CODE = result_q.err;
    assign bus.BYTE_READY      = byte_ready_q;

endmodule

// File: tb/tb_mouse_receiver.sv
// Self-checking bench for mouse_receiver driven by a behavioural PS/2 mouse model.
module tb_mouse_receiver;

    logic CLK = 1'b0;
    logic RESET;
    mouse_receiver_if bus();

    mouse_receiver dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #10 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [9:0] got_q[$];
    logic [7:0] last_byte;

    // Record every cycle BYTE_READY is seen high as {error_code, byte}.
    always @(negedge CLK) begin
        if (bus.BYTE_READY !== 1'b0) got_q.push_back({bus.BYTE_ERROR_CODE, bus.BYTE_READ});
    end

    // Reference: odd parity over data+parity bit, stop bit must be 1.
    function automatic logic [9:0] model(input logic [7:0] d, input logic p, input logic s);
        logic [1:0] e;
        e[0] = ((($countones(d) + int'(p)) % 2) == 0);
        e[1] = (s == 1'b0);
        return {e, d};
    endfunction

    task automatic send_bit(input logic b, input int half, input bit glitch);
        bus.DATA_MOUSE_IN = b;
        if (glitch) begin
            repeat (half / 2) @(posedge CLK);
            bus.CLK_MOUSE_IN = 1'b0;
            repeat (2) @(posedge CLK);
            bus.CLK_MOUSE_IN = 1'b1;
            repeat (half - half / 2 - 2) @(posedge CLK);
        end else begin
            repeat (half) @(posedge CLK);
        end
        bus.CLK_MOUSE_IN = 1'b0;
        repeat (half) @(posedge CLK);
        bus.CLK_MOUSE_IN = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int half,
                              input int nbits, input int re_drop, input bit glitch);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[i], half, glitch);
            if (i == re_drop) bus.READ_ENABLE = 1'b0;
        end
        bus.DATA_MOUSE_IN = 1'b1;
        repeat (30) @(posedge CLK);
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        bus.CLK_MOUSE_IN = 1'b1;
        bus.DATA_MOUSE_IN = 1'b1;
        bus.READ_ENABLE = 1'b1;
        repeat (5) @(negedge CLK);
        checks++; if (bus.BYTE_READ !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", bus.BYTE_READ); end
        checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", bus.BYTE_ERROR_CODE); end
        checks++; if (bus.BYTE_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.BYTE_READY); end
        @(posedge CLK);
        RESET = 1'b1;
        repeat (5) @(posedge CLK);
        got_q.delete();
        last_byte = 8'h00;
    endtask

    task automatic test_known_frames();
        logic [7:0] d [3] = '{8'hFA, 8'hF4, 8'h00};
        logic       p [3] = '{1'b1, 1'b1, 1'b1};
        logic       s [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] e [3] = '{2'b00, 2'b01, 2'b10};
        int         h [3] = '{1500, 40, 40};
        for (int i = 0; i < 3; i++) begin
            got_q.delete();
            send_frame(d[i], p[i], s[i], h[i], 11, -1, 1'b0);
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL known_%0d_pulses: got %0d expected 1", i, got_q.size());
            end else begin
                checks++;
                if (got_q[0] !== {e[i], d[i]}) begin
                    errors++; $display("FAIL known_%0d_value: got %h expected %h", i, got_q[0], {e[i], d[i]});
                end
            end
            checks++;
            if (bus.BYTE_READ !== d[i]) begin errors++; $display("FAIL known_%0d_hold: got %h expected %h", i, bus.BYTE_READ, d[i]); end
            last_byte = d[i];
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic p, s;
            int half, drop;
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            half = $urandom_range(30, 60);
            drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : -1;
            got_q.delete();
            send_frame(d, p, s, half, 11, drop, 1'b0);
            bus.READ_ENABLE = 1'b1;
            checks++;
            if (got_q.size() != 1) begin
                errors++; $display("FAIL random_%0d_pulses: got %0d expected 1", n, got_q.size());
            end else begin
                checks++;
                if (got_q[0] !== model(d, p, s)) begin
                    errors++; $display("FAIL random_%0d_value: got %h expected %h", n, got_q[0], model(d, p, s));
                end
            end
            last_byte = d;
        end
    endtask

    task automatic test_timeout();
        got_q.delete();
        send_frame(8'h3C, 1'b1, 1'b1, 40, 5, -1, 1'b0);
        repeat (15000) @(posedge CLK);
        @(negedge CLK);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL timeout_pulses: got %0d expected 0", got_q.size()); end
        checks++; if (bus.BYTE_READ !== last_byte) begin errors++; $display("FAIL timeout_hold: got %h expected %h", bus.BYTE_READ, last_byte); end
        got_q.delete();
        send_frame(8'hAA, 1'b1, 1'b1, 40, 11, -1, 1'b0);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL timeout_next_pulses: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== model(8'hAA, 1'b1, 1'b1)) begin
                errors++; $display("FAIL timeout_next_value: got %h expected %h", got_q[0], model(8'hAA, 1'b1, 1'b1));
            end
        end
        last_byte = 8'hAA;
    endtask

    task automatic test_read_enable();
        got_q.delete();
        bus.READ_ENABLE = 1'b0;
        send_frame(8'hFA, 1'b1, 1'b1, 40, 11, -1, 1'b0);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL re_low_pulses: got %0d expected 0", got_q.size()); end
        checks++; if (bus.BYTE_READ !== last_byte) begin errors++; $display("FAIL re_low_hold: got %h expected %h", bus.BYTE_READ, last_byte); end
        bus.READ_ENABLE = 1'b1;
        got_q.delete();
        send_frame(8'hFA, 1'b1, 1'b1, 40, 11, 0, 1'b0);
        bus.READ_ENABLE = 1'b1;
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL re_drop_pulses: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 10'h0FA) begin errors++; $display("FAIL re_drop_value: got %h expected 0fa", got_q[0]); end
        end
        last_byte = 8'hFA;
    endtask

    task automatic test_reset_midframe();
        got_q.delete();
        send_frame(8'h33, 1'b1, 1'b1, 40, 5, -1, 1'b0);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (bus.BYTE_READ !== 8'h00) begin errors++; $display("FAIL midrst_byte: got %h expected 00", bus.BYTE_READ); end
        checks++; if (bus.BYTE_ERROR_CODE !== 2'b00) begin errors++; $display("FAIL midrst_err: got %b expected 00", bus.BYTE_ERROR_CODE); end
        checks++; if (bus.BYTE_READY !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", bus.BYTE_READY); end
        @(posedge CLK);
        RESET = 1'b1;
        repeat (5) @(posedge CLK);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL midrst_partial: got %0d pulses expected 0", got_q.size()); end
        got_q.delete();
        send_frame(8'h55, 1'b1, 1'b1, 40, 11, -1, 1'b0);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midrst_next_pulses: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 10'h055) begin errors++; $display("FAIL midrst_next_value: got %h expected 055", got_q[0]); end
        end
        last_byte = 8'h55;
    endtask

`ifdef MOUSE_RECEIVER_GLITCH_FILTER_EN
    task automatic test_glitch();
        got_q.delete();
        send_frame(8'hFA, 1'b1, 1'b1, 60, 11, -1, 1'b1);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL glitch_pulses: got %0d expected 1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 10'h0FA) begin errors++; $display("FAIL glitch_value: got %h expected 0fa", got_q[0]); end
        end
        last_byte = 8'hFA;
    endtask
`endif

    initial begin
        test_reset();
        test_known_frames();
        test_random();
        test_timeout();
        test_read_enable();
        test_reset_midframe();
`ifdef MOUSE_RECEIVER_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mouse_receiver.md
MOUSE_RECEIVER -- requirements
Module: mouse_receiver

Interface
REQ-001 SHALL have port CLK, input, 1, system clock, 50 MHz, all logic on rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port CLK_MOUSE_IN, input, 1, raw PS/2 clock line from mouse.
REQ-004 SHALL have port DATA_MOUSE_IN, input, 1, raw PS/2 data line from mouse.
REQ-005 SHALL have port READ_ENABLE, input, 1, high = new frames may start; driven low by master while transmitter owns the bus.
REQ-006 SHALL have port BYTE_READ, output, 8, last received data byte.
REQ-007 SHALL have port BYTE_ERROR_CODE, output, 2, bit0 = parity error, bit1 = stop-bit error, for last frame.
REQ-008 SHALL have port BYTE_READY, output, 1, single-cycle pulse, frame complete.

Function
REQ-009 SHALL pass CLK_MOUSE_IN and DATA_MOUSE_IN through 2-flop synchronisers; a mouse-clock falling edge = synchronised clock 1 then 0 on consecutive CLK cycles.
REQ-010 SHALL sample synchronised data on each detected falling edge; frame = start(0), 8 data LSB first, odd parity, stop(1).
REQ-011 SHALL implement states IDLE, READ_DATA, READ_PARITY, READ_STOP, SEND_BYTE.
REQ-012 IDLE -> READ_DATA on falling edge with data = 0 and READ_ENABLE = 1; edge with data = 1 or READ_ENABLE = 0 ignored.
REQ-013 READ_DATA shifts 8 bits via 3-bit counter; after bit 7 -> READ_PARITY.
REQ-014 READ_PARITY stores parity error = (XOR of 8 data bits XOR parity bit) == 0; -> READ_STOP.
REQ-015 READ_STOP stores stop error = sampled bit == 0; -> SEND_BYTE.
REQ-016 SEND_BYTE, lasting exactly one CLK cycle: BYTE_READY = 1, BYTE_READ and BYTE_ERROR_CODE updated same cycle; -> IDLE.
REQ-017 BYTE_READY SHALL pulse exactly once per completed frame, including frames with errors; BYTE_READ/BYTE_ERROR_CODE held until next SEND_BYTE.
REQ-018 Timeout counter SHALL clear on each falling edge; 10000 CLK cycles (200 us) without edge in any non-IDLE state -> IDLE, no BYTE_READY, outputs unchanged.
REQ-019 READ_ENABLE falling mid-frame SHALL NOT abort; frame completes normally.
REQ-020 Timeout and falling edge in same cycle: edge wins, counter clears.

Reset
REQ-021 RESET low SHALL force IDLE, BYTE_READ = 0x00, BYTE_ERROR_CODE = 00, BYTE_READY = 0, shift register, bit counter and timeout counter = 0, synchroniser flops = 1.
REQ-022 Reset mid-frame SHALL discard partial frame; first frame after release requires a fresh start bit.

Configuration
REQ-023 With MOUSE_RECEIVER_GLITCH_FILTER_EN defined, synchronised CLK_MOUSE_IN SHALL be accepted only after 8 consecutive equal samples; edge detection uses filtered value (adds 8 cycles latency).
REQ-024 Without MOUSE_RECEIVER_GLITCH_FILTER_EN, edge detection SHALL use the 2-flop output directly; no filter logic present.

Structure
REQ-025 Shared package mouse_ps2_pkg SHALL hold state enum, TIMEOUT_CYCLES = 10000, FILTER_LEN = 8, error-bit index constants.
REQ-026 Sub-module ps2_line_sync SHALL contain synchronisers, optional glitch filter and falling-edge detector; mouse_receiver holds FSM, shifter, counters.

Verification
REQ-027 Frame 0xFA, parity 1, stop 1, 60 us mouse-clock period -> one BYTE_READY pulse, BYTE_READ = 0xFA, BYTE_ERROR_CODE = 00.
REQ-028 Frame 0xF4 with parity 1 (wrong) -> BYTE_READY pulse, BYTE_READ = 0xF4, BYTE_ERROR_CODE = 01.
REQ-029 Frame 0x00, parity 1, stop 0 -> BYTE_READY pulse, BYTE_READ = 0x00, BYTE_ERROR_CODE = 10.
REQ-030 Start + 4 data bits, then 300 us idle clock, then good 0xAA frame -> no pulse for partial frame; one pulse, BYTE_READ = 0xAA.
REQ-031 READ_ENABLE = 0 during full 0xFA frame -> no BYTE_READY, BYTE_READ unchanged; READ_ENABLE dropped after start bit -> frame received.
REQ-032 RESET low after 5 bits, released, then 0x55 frame -> outputs 0 during reset; single pulse, BYTE_READ = 0x55; repeat REQ-027 with macro defined and 2-cycle clock glitches -> identical result.
